// File: rtl/ex_div_pkg.sv
// rtl/ex_div_pkg.sv - shared widths, funct3 codes and FSM encodings for ex_div
//
// Purpose: constants shared by the divider, its interface and the execute stage.
//   RegBus / RegAddrBus      : data and register-address widths
//   INST_DIV .. INST_REMU    : funct3 codes of the RV32M divide group
//   DIV_IDLE .. DIV_END      : 2-bit divider FSM state encodings
package ex_div_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  localparam logic [1:0] DIV_IDLE  = 2'b00;
  localparam logic [1:0] DIV_START = 2'b01;
  localparam logic [1:0] DIV_CALC  = 2'b10;
  localparam logic [1:0] DIV_END   = 2'b11;

endpackage

// File: rtl/ex_div_if.sv
// rtl/ex_div_if.sv - request/response bundle between execute and the divider
//
// Purpose: groups the divider handshake and operand signals.
//   dividend_i, divisor_i, op_i, reg_waddr_i, start_i, flush_i : execute -> divider
//   result_o, reg_waddr_o, ready_o, busy_o                     : divider -> execute
// Modports: master (execute side), slave (divider side).
interface ex_div_if;
  import ex_div_pkg::*;

  logic [RegBus-1:0]     dividend_i;
  logic [RegBus-1:0]     divisor_i;
  logic [2:0]            op_i;
  logic [RegAddrBus-1:0] reg_waddr_i;
  logic                  start_i;
  logic                  flush_i;
  logic [RegBus-1:0]     result_o;
  logic [RegAddrBus-1:0] reg_waddr_o;
  logic                  ready_o;
  logic                  busy_o;

  modport master (
    output dividend_i, divisor_i, op_i, reg_waddr_i, start_i, flush_i,
    input  result_o, reg_waddr_o, ready_o, busy_o
  );

  modport slave (
    input  dividend_i, divisor_i, op_i, reg_waddr_i, start_i, flush_i,
    output result_o, reg_waddr_o, ready_o, busy_o
  );

endinterface

// File: rtl/ex_div.sv
// rtl/ex_div.sv - multi-cycle RV32M DIV/DIVU/REM/REMU restoring divider
//
// Purpose: radix-2 restoring divider, one quotient bit per cycle, 4-state FSM
//   (IDLE, START, CALC, END). Returns result and rd with a one-cycle ready_o.
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : ex_div_if.slave (operands, op, rd, start/flush in; result, rd, ready, busy out)
// Option: DIV_FAST_PATH_EN - divide-by-zero and signed overflow skip CALC and
//   go straight from START to END (2-cycle latency instead of 34).
module ex_div
  import ex_div_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  ex_div_if.slave  bus
);

  logic [1:0]            state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [RegAddrBus-1:0] waddr_q, waddr_d;
  logic [RegBus-1:0]     dividend_q, dividend_d;  // raw rs1, kept for special results
  logic [RegBus-1:0]     divisor_q, divisor_d;    // raw rs2
  logic [RegBus-1:0]     dsr_q, dsr_d;            // |divisor| used by the iteration
  logic [RegBus-1:0]     quo_q, quo_d;
  logic [RegBus-1:0]     rem_q, rem_d;
  logic [4:0]            cnt_q, cnt_d;
  logic                  quo_neg_q, quo_neg_d;
  logic                  rem_neg_q, rem_neg_d;

  logic              is_signed, is_rem, div_zero, overflow, take_sub, ready;
  logic [RegBus-1:0] dvd_abs, dsr_abs, quo_fix, rem_fix, result;
  logic [RegBus:0]   rem_sh, diff;

  always_comb begin
    is_signed = ~op_q[0];
    is_rem    = op_q[1];
    div_zero  = (divisor_q == '0);
    overflow  = is_signed && (dividend_q == 32'h8000_0000) && (divisor_q == 32'hFFFF_FFFF);
    dvd_abs   = (is_signed && dividend_q[31]) ? (32'd0 - dividend_q) : dividend_q;
    dsr_abs   = (is_signed && divisor_q[31])  ? (32'd0 - divisor_q)  : divisor_q;

    // Shift {rem, quo} left by one; rem_sh needs 33 bits since rem < divisor may exceed 2^31.
    rem_sh   = {rem_q, quo_q[31]};
    take_sub = (rem_sh >= {1'b0, dsr_q});
    diff     = rem_sh - {1'b0, dsr_q};

    quo_fix = quo_neg_q ? (32'd0 - quo_q) : quo_q;
    rem_fix = rem_neg_q ? (32'd0 - rem_q) : rem_q;
    // Special cases override whatever the iteration produced, in either build.
    if (div_zero) begin
      quo_fix = 32'hFFFF_FFFF;
      rem_fix = dividend_q;
    end else if (overflow) begin
      quo_fix = 32'h8000_0000;
      rem_fix = '0;
    end
    result = is_rem ? rem_fix : quo_fix;

    // A flush in the END cycle suppresses the completion.
    ready           = (state_q == DIV_END) && !bus.flush_i;
    bus.ready_o     = ready;
    bus.result_o    = ready ? result : '0;
    bus.reg_waddr_o = ready ? waddr_q : '0;
    bus.busy_o      = (state_q != DIV_IDLE);
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    waddr_d    = waddr_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    dsr_d      = dsr_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    quo_neg_d  = quo_neg_q;
    rem_neg_d  = rem_neg_q;

    case (state_q)
      DIV_IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          op_d       = bus.op_i;
          waddr_d    = bus.reg_waddr_i;
          dividend_d = bus.dividend_i;
          divisor_d  = bus.divisor_i;
          state_d    = DIV_START;
        end
      end
      DIV_START: begin
        quo_d     = dvd_abs;
        dsr_d     = dsr_abs;
        rem_d     = '0;
        cnt_d     = '0;
        quo_neg_d = is_signed && (dividend_q[31] ^ divisor_q[31]);
        rem_neg_d = is_signed && dividend_q[31];
        state_d   = DIV_CALC;
`ifdef DIV_FAST_PATH_EN
        if (div_zero || overflow) begin
          state_d = DIV_END;
        end
`endif
      end
      DIV_CALC: begin
        rem_d = take_sub ? diff[RegBus-1:0] : rem_sh[RegBus-1:0];
        quo_d = {quo_q[RegBus-2:0], take_sub};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DIV_END;
        end
      end
      DIV_END: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase

    if (bus.flush_i && (state_q != DIV_IDLE)) begin
      state_d = DIV_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DIV_IDLE;
      op_q       <= '0;
      waddr_q    <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      dsr_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      waddr_q    <= waddr_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      dsr_q      <= dsr_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      quo_neg_q  <= quo_neg_d;
      rem_neg_q  <= rem_neg_d;
    end
  end

endmodule
